// File: rtl/apb_bus_tmo.sv
// rtl/apb_bus_tmo.sv - APB slave decoder/mux with stalled-access timeout and timeout statistics
module apb_bus_tmo #(
  parameter int                    NUM_SLAVES   = 16,
  parameter int                    DEC_W        = 4,
  parameter int                    DATA_W       = 32,
  parameter logic [NUM_SLAVES-1:0] PORT_EN      = '1,
  parameter int                    TIMEOUT      = 255,
  parameter logic                  UNMAPPED_ERR = 1'b1
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic [DEC_W-1:0]             DEC_BITS,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  output logic [NUM_SLAVES-1:0]        PSEL_S,
  input  logic [NUM_SLAVES-1:0]        PREADY_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_S,
  input  logic [NUM_SLAVES-1:0]        PSLVERR_S,
  output logic                         PREADY,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PSLVERR,
  output logic                         TMO_EVENT,
  output logic [15:0]                  TMO_COUNT,
  output logic [DEC_W-1:0]             ERR_IDX
);

  // Every DEC_BITS value gets a slot; slots beyond NUM_SLAVES read as a
  // disabled, never-ready, zero-data port so out-of-range indices are safe.
  localparam int NUM_IDX = 2 ** DEC_W;

  // The wait counter only has to reach 255; it saturates rather than wraps
  // so an unlimited wait (TIMEOUT = 0) never aliases back to a small value.
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);
  localparam logic       TMO_ON  = (TIMEOUT != 0);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_eff;
  logic [15:0] tmo_count;
  logic        tmo_event_q;
  logic [DEC_W-1:0] err_idx_q;

  logic [NUM_IDX-1:0] en_pad;
  logic [NUM_IDX-1:0] ready_pad;
  logic [NUM_IDX-1:0] err_pad;
  logic [DATA_W-1:0]  data_pad [NUM_IDX];

  logic              access;
  logic              mapped;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_data;
  logic              force_c;

  logic              pready_c;
  logic              pslverr_c;
  logic [DATA_W-1:0] prdata_c;

  genvar gi;

  // Widen the per-slave inputs to the full decode range.
  generate
    for (gi = 0; gi < NUM_IDX; gi++) begin : g_pad
      if (gi < NUM_SLAVES) begin : g_real
        assign en_pad[gi]    = PORT_EN[gi];
        assign ready_pad[gi] = PREADY_S[gi];
        assign err_pad[gi]   = PSLVERR_S[gi];
        assign data_pad[gi]  = PRDATA_S[gi*DATA_W +: DATA_W];
      end else begin : g_hole
        assign en_pad[gi]    = 1'b0;
        assign ready_pad[gi] = 1'b0;
        assign err_pad[gi]   = 1'b0;
        assign data_pad[gi]  = '0;
      end
    end
  endgenerate

  assign access    = PSEL & PENABLE;
  assign mapped    = en_pad[DEC_BITS];
  assign sel_ready = ready_pad[DEC_BITS];
  assign sel_err   = err_pad[DEC_BITS];
  assign sel_data  = data_pad[DEC_BITS];

  // The count is only meaningful while a stalled access is in progress.
  assign cnt_eff = (state_q == ST_WAIT) ? cnt_q : 8'd0;

  // Forced completion: the selected slave has stalled for the full limit
  // and still is not ready on this cycle.
  assign force_c = TMO_ON & access & mapped & (cnt_eff == TMO_LIM) & ~sel_ready;

  // Per-slave select; the stalled slave is deselected in the cycle its
  // access is forced to complete, and nothing is selected in reset.
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
      assign PSEL_S[gi] = PSEL & (DEC_BITS == DEC_W'(gi)) & PORT_EN[gi] & ~force_c & ~PRESET;
    end
  endgenerate

  // Next-state and bridge-side response mux; idle defaults apply outside
  // an access phase and during reset.
  always_comb begin
    state_d   = ST_IDLE;
    cnt_d     = 8'd0;
    pready_c  = 1'b1;
    pslverr_c = 1'b0;
    prdata_c  = '0;
    if (!PRESET && access) begin
      if (force_c) begin
        pslverr_c = 1'b1;
      end else if (mapped) begin
        pready_c = sel_ready;
        if (sel_ready) begin
          pslverr_c = sel_err;
          prdata_c  = sel_data;
        end
      end else begin
        pslverr_c = UNMAPPED_ERR;
      end
      if (!pready_c) begin
        state_d = ST_WAIT;
        cnt_d   = (cnt_eff == 8'hFF) ? cnt_eff : cnt_eff + 8'd1;
      end
    end
  end

  // Transfer state register; any completion or master abort returns to IDLE.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Timeout statistics: pulse, saturating count and index of last offender.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tmo_event_q <= 1'b0;
      tmo_count   <= 16'd0;
      err_idx_q   <= '0;
    end else begin
      tmo_event_q <= force_c;
      if (force_c) begin
        if (tmo_count != 16'hFFFF) begin
          tmo_count <= tmo_count + 16'd1;
        end
        err_idx_q <= DEC_BITS;
      end
    end
  end

  assign PREADY    = pready_c;
  assign PSLVERR   = pslverr_c;
  assign PRDATA    = prdata_c;
  assign TMO_EVENT = tmo_event_q;
  assign TMO_COUNT = tmo_count;
  assign ERR_IDX   = err_idx_q;

endmodule
